// File: rtl/fetch_pc_gen_if.sv
// Fetch PC generator bus: next-PC select code and candidates in, fetch PC and tags out.
interface fetch_pc_gen_if #(
  parameter int unsigned PC_W = 16
);
  localparam int unsigned SEL_W   = 3;
  localparam int unsigned EPOCH_W = 3;

  // Upstream selector and candidate addresses
  logic [SEL_W-1:0]   PC_select;
  logic [PC_W-1:0]    pred_tgt0;
  logic [PC_W-1:0]    pred_tgt1;
  logic [PC_W-1:0]    jump_tgt;
  logic [PC_W-1:0]    recovery_pc;
  logic [PC_W-1:0]    bhndlr_pc;

  // Fetch PC and side-band tags
  logic [PC_W-1:0]    pc;
  logic               pc_valid;
  logic               redirect;
  logic [EPOCH_W-1:0] epoch;
  logic               hold_timeout;
  logic               sel_err;

  // Driver side: selector/candidates out, fetch PC observed
  modport master (
    output PC_select, pred_tgt0, pred_tgt1, jump_tgt, recovery_pc, bhndlr_pc,
    input  pc, pc_valid, redirect, epoch, hold_timeout, sel_err
  );

  // PC generator side
  modport slave (
    input  PC_select, pred_tgt0, pred_tgt1, jump_tgt, recovery_pc, bhndlr_pc,
    output pc, pc_valid, redirect, epoch, hold_timeout, sel_err
  );
endinterface

// File: rtl/fetch_pc_gen.sv
// Fetch-stage PC register with next-PC mux, redirect/epoch tagging,
// hold watchdog and sticky illegal-select flag. All outputs registered.
module fetch_pc_gen #(
  parameter int unsigned PC_W       = 16,
  parameter int unsigned FETCH_INC  = 4,
  parameter int unsigned RESET_VEC  = 0,
  parameter int unsigned HOLD_LIMIT = 64
) (
  input  logic                clk,
  input  logic                rst,
  fetch_pc_gen_if.slave       bus
);

  localparam int unsigned SEL_W   = 3;
  localparam int unsigned EPOCH_W = 3;
  localparam int unsigned HCNT_W  = 8;

  localparam logic [PC_W-1:0]   PC_INC   = PC_W'(FETCH_INC);
  localparam logic [PC_W-1:0]   RST_PC   = PC_W'(RESET_VEC);
  localparam logic [HCNT_W-1:0] HOLD_LIM = HCNT_W'(HOLD_LIMIT);
  localparam logic [HCNT_W-1:0] HCNT_MAX = '1;

  typedef enum logic [SEL_W-1:0] {
    SEL_PRED0 = 3'd0,
    SEL_PRED1 = 3'd1,
    SEL_JUMP  = 3'd2,
    SEL_RECOV = 3'd3,
    SEL_BHNDL = 3'd4,
    SEL_SEQ   = 3'd5,
    SEL_HOLD  = 3'd6,
    SEL_RESET = 3'd7
  } pc_sel_e;

  pc_sel_e             sel;

  logic [PC_W-1:0]     pc_q,           pc_d;
  logic                pc_valid_q,     pc_valid_d;
  logic                redirect_q,     redirect_d;
  logic [EPOCH_W-1:0]  epoch_q,        epoch_d;
  logic [HCNT_W-1:0]   hold_cnt_q,     hold_cnt_d;
  logic                hold_timeout_q, hold_timeout_d;
  logic                sel_err_q,      sel_err_d;

  assign sel = pc_sel_e'(bus.PC_select);

  // Next-state decode: mux the fetch PC and update tags/diagnostics per select code
  always_comb begin
    pc_d           = pc_q;
    pc_valid_d     = pc_valid_q;
    redirect_d     = 1'b0;
    epoch_d        = epoch_q;
    hold_cnt_d     = '0;
    hold_timeout_d = (hold_cnt_q >= HOLD_LIM);
    sel_err_d      = sel_err_q;

    case (sel)
      SEL_PRED0: begin
        pc_d       = bus.pred_tgt0;
        pc_valid_d = 1'b1;
        redirect_d = 1'b1;
      end
      SEL_PRED1: begin
        pc_d       = bus.pred_tgt1;
        pc_valid_d = 1'b1;
        redirect_d = 1'b1;
      end
      SEL_JUMP: begin
        pc_d       = bus.jump_tgt;
        pc_valid_d = 1'b1;
        redirect_d = 1'b1;
      end
      SEL_RECOV: begin
        pc_d       = bus.recovery_pc;
        pc_valid_d = 1'b1;
        redirect_d = 1'b1;
        epoch_d    = epoch_q + 3'd1;
      end
      SEL_BHNDL: begin
        pc_d       = bus.bhndlr_pc;
        pc_valid_d = 1'b1;
        redirect_d = 1'b1;
      end
      SEL_SEQ: begin
        // Truncating add wraps silently at the top of the address space
        pc_d       = pc_q + PC_INC;
        pc_valid_d = 1'b1;
      end
      SEL_HOLD: begin
        hold_cnt_d = (hold_cnt_q == HCNT_MAX) ? hold_cnt_q : hold_cnt_q + 8'd1;
      end
      SEL_RESET: begin
        pc_d       = RST_PC;
        pc_valid_d = 1'b0;
        sel_err_d  = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // State register with synchronous reset overriding any select code
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q           <= RST_PC;
      pc_valid_q     <= 1'b0;
      redirect_q     <= 1'b0;
      epoch_q        <= '0;
      hold_cnt_q     <= '0;
      hold_timeout_q <= 1'b0;
      sel_err_q      <= 1'b0;
    end else begin
      pc_q           <= pc_d;
      pc_valid_q     <= pc_valid_d;
      redirect_q     <= redirect_d;
      epoch_q        <= epoch_d;
      hold_cnt_q     <= hold_cnt_d;
      hold_timeout_q <= hold_timeout_d;
      sel_err_q      <= sel_err_d;
    end
  end

  assign bus.pc           = pc_q;
  assign bus.pc_valid     = pc_valid_q;
  assign bus.redirect     = redirect_q;
  assign bus.epoch        = epoch_q;
  assign bus.hold_timeout = hold_timeout_q;
  assign bus.sel_err      = sel_err_q;

endmodule

// File: tb/tb_fetch_pc_gen.sv
// Directed scoreboard bench for fetch_pc_gen (PC_W=16, FETCH_INC=4, RESET_VEC=0, HOLD_LIMIT=3).
module tb_fetch_pc_gen;

  logic clk = 1'b0;
  logic rst = 1'b1;

  fetch_pc_gen_if #(.PC_W(16)) bus ();

  fetch_pc_gen #(
    .PC_W      (16),
    .FETCH_INC (4),
    .RESET_VEC (0),
    .HOLD_LIMIT(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          idx;
    bit          rst;
    logic [2:0]  code;
    logic [15:0] cand;
    logic [15:0] pc;
    bit          v;
    bit          rd;
    logic [2:0]  ep;
    bit          ht;
    bit          se;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];

  int n_tests = 0;
  int n_fail  = 0;

  // Append one directed vector: inputs for an edge and expected outputs after it
  task automatic addv(input bit r, input int code, input int cand, input int pc,
                      input bit v, input bit rd, input int ep, input bit ht, input bit se);
    vec_t t;
    t.idx  = vecs.size();
    t.rst  = r;
    t.code = 3'(code);
    t.cand = 16'(cand);
    t.pc   = 16'(pc);
    t.v    = v;
    t.rd   = rd;
    t.ep   = 3'(ep);
    t.ht   = ht;
    t.se   = se;
    vecs.push_back(t);
  endtask

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s vec%0d: got 0x%0h expected 0x%0h", name, idx, act, exp);
    end
  endtask

  // Monitor: compare registered outputs away from the active edge
  initial begin
    vec_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("pc",           e.idx, 32'(bus.pc),           32'(e.pc));
        chk("pc_valid",     e.idx, 32'(bus.pc_valid),     32'(e.v));
        chk("redirect",     e.idx, 32'(bus.redirect),     32'(e.rd));
        chk("epoch",        e.idx, 32'(bus.epoch),        32'(e.ep));
        chk("hold_timeout", e.idx, 32'(bus.hold_timeout), 32'(e.ht));
        chk("sel_err",      e.idx, 32'(bus.sel_err),      32'(e.se));
      end
    end
  end

  // Driver: apply each vector, push its expectation after the capturing edge
  initial begin
    bus.PC_select   = 3'd5;
    bus.pred_tgt0   = '0;
    bus.pred_tgt1   = '0;
    bus.jump_tgt    = '0;
    bus.recovery_pc = '0;
    bus.bhndlr_pc   = '0;

    //    rst code cand     pc      v  rd ep ht se
    // reset then sequential run
    addv(1, 5, 0,       16'h0000, 0, 0, 0, 0, 0);
    addv(1, 5, 0,       16'h0000, 0, 0, 0, 0, 0);
    addv(0, 5, 0,       16'h0004, 1, 0, 0, 0, 0);
    addv(0, 5, 0,       16'h0008, 1, 0, 0, 0, 0);
    addv(0, 5, 0,       16'h000C, 1, 0, 0, 0, 0);
    addv(0, 5, 0,       16'h0010, 1, 0, 0, 0, 0);
    // each source, back-to-back redirects
    addv(0, 0, 16'h100, 16'h0100, 1, 1, 0, 0, 0);
    addv(0, 1, 16'h200, 16'h0200, 1, 1, 0, 0, 0);
    addv(0, 2, 16'h300, 16'h0300, 1, 1, 0, 0, 0);
    addv(0, 3, 16'h400, 16'h0400, 1, 1, 1, 0, 0);
    addv(0, 4, 16'h500, 16'h0500, 1, 1, 1, 0, 0);
    // hold and watchdog (limit 3)
    addv(0, 2, 16'h040, 16'h0040, 1, 1, 1, 0, 0);
    addv(0, 6, 0,       16'h0040, 1, 0, 1, 0, 0);
    addv(0, 6, 0,       16'h0040, 1, 0, 1, 0, 0);
    addv(0, 6, 0,       16'h0040, 1, 0, 1, 0, 0);
    addv(0, 6, 0,       16'h0040, 1, 0, 1, 1, 0);
    addv(0, 6, 0,       16'h0040, 1, 0, 1, 1, 0);
    addv(0, 5, 0,       16'h0044, 1, 0, 1, 1, 0);
    addv(0, 5, 0,       16'h0048, 1, 0, 1, 0, 0);
    // sequential wrap
    addv(0, 2, 16'hFFFC, 16'hFFFC, 1, 1, 1, 0, 0);
    addv(0, 5, 0,        16'h0000, 1, 0, 1, 0, 0);
    // reset overrides a recovery code: epoch stays 0
    addv(1, 3, 16'h0BAD, 16'h0000, 0, 0, 0, 0, 0);
    // nine recoveries wrap the epoch to 1
    for (int k = 0; k < 9; k++)
      addv(0, 3, 16'h1000 + 4 * k, 16'h1000 + 4 * k, 1, 1, (k + 1) % 8, 0, 0);
    // illegal select: sticky error until reset
    addv(0, 7, 16'h0BAD, 16'h0000, 0, 0, 1, 0, 1);
    addv(0, 5, 0,        16'h0004, 1, 0, 1, 0, 1);
    addv(0, 6, 0,        16'h0004, 1, 0, 1, 0, 1);
    addv(0, 6, 0,        16'h0004, 1, 0, 1, 0, 1);
    addv(0, 6, 0,        16'h0004, 1, 0, 1, 0, 1);
    addv(0, 6, 0,        16'h0004, 1, 0, 1, 1, 1);
    addv(0, 2, 16'h0250, 16'h0250, 1, 1, 1, 1, 1);
    // reset mid-redirect and mid-timeout
    addv(1, 2, 16'h0777, 16'h0000, 0, 0, 0, 0, 0);
    addv(0, 5, 0,        16'h0004, 1, 0, 0, 0, 0);

    foreach (vecs[i]) begin
      @(negedge clk);
      rst             = vecs[i].rst;
      bus.PC_select   = vecs[i].code;
      bus.pred_tgt0   = 16'($urandom);
      bus.pred_tgt1   = 16'($urandom);
      bus.jump_tgt    = 16'($urandom);
      bus.recovery_pc = 16'($urandom);
      bus.bhndlr_pc   = 16'($urandom);
      case (vecs[i].code)
        3'd0: bus.pred_tgt0   = vecs[i].cand;
        3'd1: bus.pred_tgt1   = vecs[i].cand;
        3'd2: bus.jump_tgt    = vecs[i].cand;
        3'd3: bus.recovery_pc = vecs[i].cand;
        3'd4: bus.bhndlr_pc   = vecs[i].cand;
        default: begin
        end
      endcase
      @(posedge clk);
      exp_q.push_back(vecs[i]);
    end

    for (int k = 0; k < 10 && exp_q.size() != 0; k++) @(negedge clk);
    @(negedge clk);
    if (exp_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0 pending", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global time bound
  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
